// File: rtl/vga_pkg.sv
// Shared framebuffer constants and read-path state encoding, used by both
// the pixel reader and the plot path so the two agree on layout.
package vga_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int COL_W_DEF = 3;

  // Bit positions inside the CPU-facing status word
  localparam int ST_VALID = 7;
  localparam int ST_ERR   = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/vga_addr_calc.sv
// Combinational (x,y) -> linear framebuffer address plus in-range flag.
// Row-major layout: addr = y * H_RES + x.
module vga_addr_calc
  import vga_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 15
) (
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext    = ADDR_W'(x);
  assign y_ext    = ADDR_W'(y);
  assign in_range = (32'(x) < H_RES) && (32'(y) < V_RES);

  // 160 = 128 + 32, so the default width needs only two shifts and an add
  generate
    if (H_RES == 160) begin : g_shift
      assign addr = (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin : g_mul
      assign addr = (y_ext * ADDR_W'(H_RES)) + x_ext;
    end
  endgenerate

endmodule

// File: rtl/vga_pixel_reader.sv
// CPU read-back of a single framebuffer pixel: edge-triggered request,
// bounds check, one read strobe, latency-aware capture, status word out.
module vga_pixel_reader
  import vga_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 15,
  parameter int COL_W  = COL_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [COL_W-1:0]  fb_data,
  output logic [7:0]        status,
  output logic              busy
);

  rd_state_e         state_q;
  logic              req_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_rd_q;
  logic [7:0]        status_q;
  logic              busy_q;
  logic [1:0]        cnt_q;
  logic [COL_W-1:0]  colour_q;
  logic              err_q;

  logic              start;
  logic [ADDR_W-1:0] calc_addr;
  logic              calc_ok;
  logic [7:0]        status_d;

  assign start = rd_req && !req_q;

  vga_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x        (x_q),
    .y        (y_q),
    .addr     (calc_addr),
    .in_range (calc_ok)
  );

  always_comb begin
    status_d                = '0;
    status_d[ST_VALID]      = 1'b1;
    status_d[ST_ERR]        = err_q;
    status_d[COL_W-1:0]     = colour_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fb_addr_q <= '0;
      fb_rd_q   <= 1'b0;
      status_q  <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      colour_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      // Edge tracking runs in every state so a held level never retriggers
      req_q   <= rd_req;
      fb_rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q                <= x;
            y_q                <= y;
            status_q[ST_VALID] <= 1'b0;
            busy_q             <= 1'b1;
            state_q            <= CHECK;
          end
        end
        CHECK: begin
          if (calc_ok) begin
            fb_addr_q <= calc_addr;
            fb_rd_q   <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            err_q    <= 1'b1;
            colour_q <= '0;
            state_q  <= DONE;
          end
        end
        ISSUE: begin
          cnt_q   <= 2'(RD_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            colour_q <= fb_data;
            err_q    <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          status_q <= status_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_addr = fb_addr_q;
  assign fb_rd   = fb_rd_q;
  assign status  = status_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_vga_pixel_reader.sv
// Directed bench: one reader at RD_LAT=1 backed by a memory model, one at
// RD_LAT=3 whose read data is driven cycle by cycle from the bench.
module tb_vga_pixel_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        rd_req1, rd_req3;
  logic [14:0] fb_addr1, fb_addr3;
  logic        fb_rd1, fb_rd3;
  logic [2:0]  fb_data1, fb_data3;
  logic [7:0]  status1, status3;
  logic        busy1, busy3;

  int checks = 0;
  int errors = 0;
  int rd_cnt1 = 0;
  int rd_cnt3 = 0;
  int base;

  logic [2:0] mem [0:32767];

  always #5 clk = ~clk;

  vga_pixel_reader #(.RD_LAT(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .rd_req  (rd_req1),
    .fb_addr (fb_addr1),
    .fb_rd   (fb_rd1),
    .fb_data (fb_data1),
    .status  (status1),
    .busy    (busy1)
  );

  vga_pixel_reader #(.RD_LAT(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .rd_req  (rd_req3),
    .fb_addr (fb_addr3),
    .fb_rd   (fb_rd3),
    .fb_data (fb_data3),
    .status  (status3),
    .busy    (busy3)
  );

  // Single-cycle read port; outside a read it returns a distinct junk value
  always @(posedge clk) fb_data1 <= fb_rd1 ? mem[fb_addr1] : 3'b010;

  always @(posedge clk) begin
    if (fb_rd1) rd_cnt1 <= rd_cnt1 + 1;
    if (fb_rd3) rd_cnt3 <= rd_cnt3 + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Fresh rising edge on rd_req1, then measure cycles until status valid
  task automatic read1(input string tag, input logic [7:0] xx, input logic [6:0] yy,
                       input logic [7:0] exp_st, input int exp_lat);
    int lat;
    lat = -1;
    rd_req1 = 1'b0;
    tick();
    x = xx;
    y = yy;
    rd_req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (status1[7]) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " status"}, status1, exp_st);
    check({tag, " busy"}, busy1, 1'b0);
    $display("read x=%0d y=%0d status=%02h latency=%0d", xx, yy, status1, lat);
    rd_req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'b000;
    mem[19199] = 3'b101;
    mem[159]   = 3'b110;
    mem[19040] = 3'b001;
    mem[330]   = 3'b100;
    mem[2]     = 3'b111;

    reset = 1'b0;
    x = '0;
    y = '0;
    rd_req1 = 1'b0;
    rd_req3 = 1'b0;
    fb_data3 = 3'b000;

    repeat (3) tick();
    check("rst status", status1, 8'h00);
    check("rst busy", busy1, 1'b0);
    check("rst addr", fb_addr1, 15'd0);
    check("rst status3", status3, 8'h00);
    reset = 1'b1;
    repeat (20) tick();
    check("idle no rd1", rd_cnt1, 0);
    check("idle no rd3", rd_cnt3, 0);
    check("idle status", status1, 8'h00);
    check("idle busy", busy1, 1'b0);

    // Cycle-by-cycle walk of an in-range read at the far corner
    x = 8'd159;
    y = 7'd119;
    rd_req1 = 1'b1;
    tick();
    check("corner busy", busy1, 1'b1);
    check("corner valid clr", status1[7], 1'b0);
    x = 8'd0;
    y = 7'd0;
    tick();
    check("corner fb_rd", fb_rd1, 1'b1);
    check("corner addr", fb_addr1, 15'd19199);
    tick();
    check("corner fb_rd off", fb_rd1, 1'b0);
    tick();
    check("corner not yet", status1[7], 1'b0);
    tick();
    check("corner status", status1, 8'h85);
    check("corner busy off", busy1, 1'b0);
    check("corner rd count", rd_cnt1, 1);
    $display("read x=159 y=119 status=%02h", status1);
    rd_req1 = 1'b0;

    read1("oor x160", 8'd160, 7'd5, 8'hC0, 2);
    read1("oor y120", 8'd0, 7'd120, 8'hC0, 2);
    read1("oor x255", 8'd255, 7'd0, 8'hC0, 2);
    read1("oor y127", 8'd0, 7'd127, 8'hC0, 2);
    check("oor no rd", rd_cnt1, 1);
    check("addr hold", fb_addr1, 15'd19199);
    read1("row0 end", 8'd159, 7'd0, 8'h86, 4);
    check("row0 addr", fb_addr1, 15'd159);
    read1("last row", 8'd0, 7'd119, 8'h81, 4);
    check("last row addr", fb_addr1, 15'd19040);

    // Held level plus a re-toggle while busy must produce a single read
    base = rd_cnt1;
    rd_req1 = 1'b0;
    tick();
    x = 8'd10;
    y = 7'd2;
    rd_req1 = 1'b1;
    tick();
    tick();
    tick();
    rd_req1 = 1'b0;
    tick();
    rd_req1 = 1'b1;
    repeat (8) tick();
    check("held one read", rd_cnt1 - base, 1);
    check("held status", status1, 8'h84);
    check("held addr", fb_addr1, 15'd330);
    rd_req1 = 1'b0;
    tick();
    rd_req1 = 1'b1;
    repeat (8) tick();
    check("reraise read", rd_cnt1 - base, 2);
    check("reraise status", status1, 8'h84);
    $display("held request reads=%0d status=%02h", rd_cnt1 - base, status1);
    rd_req1 = 1'b0;

    // RD_LAT=3: data is only correct in the one cycle it should be sampled
    tick();
    x = 8'd0;
    y = 7'd1;
    rd_req3 = 1'b1;
    fb_data3 = 3'b100;
    for (int i = 0; i <= 6; i++) begin
      tick();
      fb_data3 = (i == 4) ? 3'b011 : 3'b100;
      if (i == 1) begin
        check("lat3 fb_rd", fb_rd3, 1'b1);
        check("lat3 addr", fb_addr3, 15'd160);
      end
      if (i == 5) check("lat3 early", status3[7], 1'b0);
      if (i == 6) check("lat3 status", status3, 8'h83);
    end
    check("lat3 rd count", rd_cnt3, 1);
    check("lat3 busy", busy3, 1'b0);
    $display("read lat3 x=0 y=1 status=%02h", status3);
    rd_req3 = 1'b0;

    // Abort a read in WAIT with reset
    tick();
    rd_req3 = 1'b1;
    tick();
    tick();
    tick();
    check("abort in wait busy", busy3, 1'b1);
    reset = 1'b0;
    rd_req3 = 1'b0;
    #1;
    check("abort status3", status3, 8'h00);
    check("abort busy3", busy3, 1'b0);
    check("abort addr3", fb_addr3, 15'd0);
    check("abort fb_rd3", fb_rd3, 1'b0);
    check("abort status1", status1, 8'h00);
    base = rd_cnt3;
    tick();
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("post rst no rd", rd_cnt3 - base, 0);
    check("post rst status3", status3, 8'h00);
    read1("after rst", 8'd2, 7'd0, 8'h87, 4);
    check("after rst addr", fb_addr1, 15'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
